// File: rtl/tl_source_arbiter.sv
// tl_source_arbiter
// Shares one TileLink-style A channel between N_REQ requesters and routes
// D-channel responses back to the requester whose source ID they carry.
// Requester i always issues with source ID i.
//
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   req_valid/ready/last/data per-requester A beats (data packed i*DATA_W)
//   a_valid/ready/source/data/last   downstream A channel
//   d_valid/ready/source/last/data   downstream D channel
//   rsp_valid/ready           per-requester response handshake
//   rsp_data, rsp_last        D payload broadcast to all requesters
//   err_unexpected_d          one-cycle pulse after a dropped D beat
//   busy                      any source outstanding or grant locked
//   state_dbg                 arbiter FSM state (0 = IDLE, 1 = LOCKED)
//
// Handshake: every channel uses valid/ready. A beat transfers on the cycle
// where valid and ready are both high. Valid never depends on ready of the
// same channel; ready may depend on valid.
module tl_source_arbiter #(
  parameter int N_REQ        = 2,
  parameter int SRC_W        = 1,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    a_valid,
  input  logic                    a_ready,
  output logic [SRC_W-1:0]        a_source,
  output logic [DATA_W-1:0]       a_data,
  output logic                    a_last,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [SRC_W-1:0]        d_source,
  input  logic                    d_last,
  input  logic [DATA_W-1:0]       d_data,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_last,
  output logic                    err_unexpected_d,
  output logic                    busy,
  output logic                    state_dbg
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   rr_ptr, grant_q, grant, pick_idx;
  logic               pick_found;
  logic [N_REQ-1:0]   elig;
  logic [CNT_W-1:0]   cnt [N_REQ];
  logic [N_REQ-1:0]   cnt_inc, cnt_dec, cnt_nz;
  logic               a_fire, d_fire, d_expected, d_sel_ready, err_q;
  int                 idx;

  // A requester may start a new request only while below its cap.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_INFLIGHT));
    end
  end

  // Round-robin pick: scan downward so the candidate closest to rr_ptr
  // (smallest offset) is the last one written and wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (elig[idx]) begin
        pick_found = 1'b1;
        pick_idx   = SRC_W'(idx);
      end
    end
  end

  // A path mux. While LOCKED the cap is ignored: the burst must complete.
  always_comb begin
    grant   = (state == LOCKED) ? grant_q : pick_idx;
    a_valid = 1'b0;
    if (reset_n) begin
      a_valid = (state == LOCKED) ? req_valid[grant] : pick_found;
    end
    a_source         = grant;
    a_last           = req_last[grant];
    a_data           = req_data[int'(grant)*DATA_W +: DATA_W];
    req_ready        = '0;
    req_ready[grant] = a_valid & a_ready;
  end

  assign a_fire = a_valid & a_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_fire && !a_last) state_nxt = LOCKED;
      LOCKED:  if (a_fire && a_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // D routing. Expectation uses the pre-update count, so a response racing
  // its own first request is dropped as unexpected.
  always_comb begin
    d_expected  = 1'b0;
    d_sel_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (d_source == SRC_W'(i)) begin
        d_expected  = (cnt[i] != '0);
        d_sel_ready = rsp_ready[i];
      end
    end
    rsp_valid = '0;
    d_ready   = 1'b0;
    if (reset_n) begin
      d_ready = d_expected ? d_sel_ready : 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid[i] = d_valid & d_expected & (d_source == SRC_W'(i));
      end
    end
  end

  assign d_fire = d_valid & d_ready;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_inc[i] = a_fire & a_last & (grant == SRC_W'(i));
      cnt_dec[i] = d_fire & d_last & d_expected & (d_source == SRC_W'(i));
      cnt_nz[i]  = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (a_fire && (state == IDLE) && !a_last) grant_q <= grant;
      if (a_fire && a_last) begin
        rr_ptr <= (int'(grant) == N_REQ - 1) ? '0 : grant + SRC_W'(1);
      end
      err_q <= d_fire & ~d_expected;
    end
  end

  // Counters saturate at both ends; a simultaneous inc and dec cancel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign rsp_data         = d_data;
  assign rsp_last         = d_last;
  assign err_unexpected_d = err_q;
  assign busy             = (state == LOCKED) | (|cnt_nz);
  assign state_dbg        = (state == LOCKED);

endmodule

// File: tb/tb_tl_source_arbiter.sv
module tb_tl_source_arbiter;

  logic        clock, reset_n;
  logic [1:0]  req_valid, req_ready, req_last;
  logic [63:0] req_data;
  logic        a_valid, a_ready, a_last;
  logic [0:0]  a_source, d_source;
  logic [31:0] a_data, d_data, rsp_data;
  logic        d_valid, d_ready, d_last;
  logic [1:0]  rsp_valid, rsp_ready;
  logic        rsp_last, err_unexpected_d, busy, state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  tl_source_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_data(req_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_source(a_source),
    .a_data(a_data), .a_last(a_last),
    .d_valid(d_valid), .d_ready(d_ready), .d_source(d_source),
    .d_last(d_last), .d_data(d_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .err_unexpected_d(err_unexpected_d),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_last = 2'b11; a_ready = 1'b0;
    d_valid = 1'b0; d_source = 1'b0; d_last = 1'b0; d_data = '0;
    rsp_ready = 2'b00;
  endtask

  // Return n responses for one source, each one expected.
  task automatic drain(input logic src, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      idle_inputs();
      d_valid = 1'b1; d_source = src; d_last = 1'b1;
      d_data = $urandom_range(32'h7fff_ffff, 0);
      rsp_ready = src ? 2'b10 : 2'b01;
      #1;
      check("drain_rsp_valid", {30'd0, rsp_valid}, src ? 32'd2 : 32'd1);
      check("drain_d_ready", {31'd0, d_ready}, 32'd1);
      check("drain_rsp_data", rsp_data, d_data);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    int beats;
    reset_n  = 1'b0;
    req_data = {32'hB000_0001, 32'hA000_0000};
    idle_inputs();
    req_valid = 2'b11;
    a_ready   = 1'b1;
    d_valid   = 1'b1;
    #1;
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err_unexpected_d}, 32'd0);

    // Fairness: both valid, single beats
    @(negedge clock);
    reset_n = 1'b1;
    idle_inputs();
    req_valid = 2'b11; a_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      check("rr_a_valid", {31'd0, a_valid}, 32'd1);
      check("rr_a_source", {31'd0, a_source}, c % 2);
      check("rr_a_data", a_data, (c % 2) ? 32'hB000_0001 : 32'hA000_0000);
      check("rr_req_ready", {30'd0, req_ready}, (c % 2) ? 32'd2 : 32'd1);
    end
    @(negedge clock);
    idle_inputs();
    check("rr_cnt0", {29'd0, dut.cnt[0]}, 32'd3);
    check("rr_cnt1", {29'd0, dut.cnt[1]}, 32'd3);
    check("rr_busy", {31'd0, busy}, 32'd1);
    drain(1'b0, 3);
    drain(1'b1, 3);
    check("drained_busy", {31'd0, busy}, 32'd0);

    // Burst lock: requester 0 sends 4 beats, a_ready toggles 1,0
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      req_valid = (c == 3) ? 2'b10 : 2'b11;
      req_last  = {1'b1, (beats == 3)};
      a_ready   = (c % 2 == 0);
      #1;
      if (c < 7) begin
        check("burst_a_source", {31'd0, a_source}, 32'd0);
        check("burst_a_valid", {31'd0, a_valid}, (c == 3) ? 32'd0 : 32'd1);
        check("burst_req_ready", {30'd0, req_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      end else begin
        check("post_burst_a_source", {31'd0, a_source}, 32'd1);
        check("post_burst_state", {31'd0, state_dbg}, 32'd0);
      end
      if (c == 1) check("burst_locked", {31'd0, state_dbg}, 32'd1);
      if (c % 2 == 0) beats++;
    end
    @(negedge clock);
    idle_inputs();
    check("burst_cnt0", {29'd0, dut.cnt[0]}, 32'd1);
    check("burst_cnt1", {29'd0, dut.cnt[1]}, 32'd0);
    drain(1'b0, 1);

    // Cap: four single beats from requester 0
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clock);
      req_valid = 2'b01; a_ready = 1'b1;
      #1;
      check("cap_fill_a_source", {31'd0, a_source}, 32'd0);
      check("cap_fill_a_valid", {31'd0, a_valid}, 32'd1);
    end
    @(negedge clock);
    #1;
    check("capped_a_valid", {31'd0, a_valid}, 32'd0);
    check("capped_req_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clock);
    req_valid = 2'b11;
    #1;
    check("capped_other_src", {31'd0, a_source}, 32'd1);
    check("capped_other_ready", {30'd0, req_ready}, 32'd2);
    @(negedge clock);
    idle_inputs();
    d_valid = 1'b1; d_source = 1'b0; d_last = 1'b1; rsp_ready = 2'b01;
    #1;
    check("cap_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    @(negedge clock);
    idle_inputs();
    req_valid = 2'b01; a_ready = 1'b1;
    #1;
    check("uncap_a_valid", {31'd0, a_valid}, 32'd1);
    check("uncap_req_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clock);
    idle_inputs();
    check("uncap_cnt0", {29'd0, dut.cnt[0]}, 32'd4);
    drain(1'b0, 4);
    drain(1'b1, 1);

    // Unexpected D for a source with nothing outstanding
    d_valid = 1'b1; d_source = 1'b1; d_last = 1'b1; rsp_ready = 2'b11;
    #1;
    check("unexp_d_ready", {31'd0, d_ready}, 32'd1);
    check("unexp_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("unexp_err_early", {31'd0, err_unexpected_d}, 32'd0);
    @(negedge clock);
    idle_inputs();
    check("unexp_err", {31'd0, err_unexpected_d}, 32'd1);
    check("unexp_cnt1", {29'd0, dut.cnt[1]}, 32'd0);
    @(negedge clock);
    check("unexp_err_clear", {31'd0, err_unexpected_d}, 32'd0);

    // Simultaneous inc/dec on source 0 with cnt = 2
    req_valid = 2'b01; a_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("sim_pre_cnt0", {29'd0, dut.cnt[0]}, 32'd2);
    d_valid = 1'b1; d_source = 1'b0; d_last = 1'b1; rsp_ready = 2'b01;
    #1;
    check("sim_a_valid", {31'd0, a_valid}, 32'd1);
    check("sim_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    @(negedge clock);
    idle_inputs();
    check("sim_cnt0", {29'd0, dut.cnt[0]}, 32'd2);
    drain(1'b0, 2);

    // Response racing its own first request is dropped
    req_valid = 2'b10; a_ready = 1'b1;
    d_valid = 1'b1; d_source = 1'b1; d_last = 1'b1; rsp_ready = 2'b10;
    #1;
    check("race_a_source", {31'd0, a_source}, 32'd1);
    check("race_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("race_d_ready", {31'd0, d_ready}, 32'd1);
    @(negedge clock);
    idle_inputs();
    check("race_err", {31'd0, err_unexpected_d}, 32'd1);
    check("race_cnt1", {29'd0, dut.cnt[1]}, 32'd1);
    drain(1'b1, 1);

    // Async reset mid-burst; round robin restarts at requester 0
    req_valid = 2'b01; a_ready = 1'b1;
    @(negedge clock);
    req_last = 2'b00;
    @(negedge clock);
    #1;
    check("mid_burst_locked", {31'd0, state_dbg}, 32'd1);
    check("mid_burst_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_a_valid", {31'd0, a_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_state", {31'd0, state_dbg}, 32'd0);
    check("arst_cnt0", {29'd0, dut.cnt[0]}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_inputs();
    req_valid = 2'b11;
    #1;
    check("arst_restart_src", {31'd0, a_source}, 32'd0);
    check("arst_restart_valid", {31'd0, a_valid}, 32'd1);
    @(negedge clock);
    idle_inputs();
    d_valid = 1'b1; d_source = 1'b0; d_last = 1'b1; rsp_ready = 2'b01;
    #1;
    check("stale_d_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("stale_d_ready", {31'd0, d_ready}, 32'd1);
    @(negedge clock);
    idle_inputs();
    check("stale_d_err", {31'd0, err_unexpected_d}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_source_arbiter.md
Name: tl_source_arbiter

Overview:
- Shares one TileLink-style A channel between N_REQ requesters and returns D-channel responses to the requester that issued them.
- Each requester owns a fixed source ID equal to its index. Multi-beat A bursts keep the grant until the last beat.
- Outstanding transactions are counted per source and capped. Any D response that matches no outstanding request is dropped and flagged, so the protocol checker never sees it downstream.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- SRC_W, 1, width of a_source/d_source; must satisfy 2^SRC_W >= N_REQ
- DATA_W, 32, payload width for A and D
- MAX_INFLIGHT, 4, maximum outstanding transactions per source (1..7)
- CNT_W, 3, width of each outstanding counter; must hold MAX_INFLIGHT

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester A beat valid
- req_ready  out  N_REQ  per-requester A beat accepted
- req_last  in  N_REQ  marks the final beat of a request
- req_data  in  N_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W]
- a_valid  out  1  downstream A valid
- a_ready  in  1  downstream A ready
- a_source  out  SRC_W  index of the granted requester
- a_data  out  DATA_W  payload of the granted requester
- a_last  out  1  req_last of the granted requester
- d_valid  in  1  downstream D valid
- d_ready  out  1  D accepted
- d_source  in  SRC_W  response source ID
- d_last  in  1  final beat of the response
- d_data  in  DATA_W  response payload
- rsp_valid  out  N_REQ  per-requester response valid
- rsp_ready  in  N_REQ  per-requester response ready
- rsp_data  out  DATA_W  d_data broadcast to all requesters
- rsp_last  out  1  d_last broadcast to all requesters
- err_unexpected_d  out  1  one-cycle pulse when an unexpected D response is dropped
- busy  out  1  high while any outstanding counter is non-zero or the grant is locked

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, rr_ptr=0, all counters=0, grant index=0, err_unexpected_d=0.
  - Combinational outputs are forced inactive: a_valid=0, req_ready=0, rsp_valid=0, d_ready=0.
- Eligibility: requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_INFLIGHT.
- State machine, two states:
  - IDLE: pick the first eligible requester searching from rr_ptr upward, wrapping modulo N_REQ. The pick is combinational, so a_valid is asserted in the same cycle (zero added latency).
    - On an A fire with a_last=1: stay IDLE and set rr_ptr = grant+1 (mod N_REQ).
    - On an A fire with a_last=0: register the grant and go to LOCKED.
    - If there is no fire, the grant is not held; arbitration is re-evaluated next cycle.
  - LOCKED: only the registered requester is muxed. a_valid = req_valid[grant], and the eligibility cap is ignored mid-burst. An A fire with a_last=1 returns to IDLE and sets rr_ptr = grant+1.
- A path: a_source, a_data and a_last come from the granted requester. req_ready[grant] = a_ready & a_valid; all other req_ready bits are 0. An A fire is a_valid & a_ready.
- Counters:
  - cnt[s] increments on an A fire with a_last=1 and a_source=s.
  - cnt[s] decrements on an accepted D fire with d_last=1 and d_source=s.
  - An increment and decrement of the same source in the same cycle leaves cnt[s] unchanged.
  - A counter never wraps.
- D routing, combinational:
  - The response is expected when d_source < N_REQ and cnt[d_source] != 0.
  - Expected: rsp_valid[d_source] = d_valid and d_ready = rsp_ready[d_source]; all other rsp_valid bits are 0.
  - Unexpected: d_ready=1 and all rsp_valid=0, so the beat is dropped. err_unexpected_d pulses for exactly the cycle after each dropped beat (registered).
- Boundary cases:
  - All requesters capped or not valid: a_valid=0.
  - A requester drops req_valid while LOCKED: a_valid=0 and the lock is held; no other requester is granted.
  - A response for source s arriving in the same cycle as s's first request fires: it is treated as unexpected, because the check uses the pre-update count.
- Reset asserted mid-burst or mid-response: everything clears immediately; any in-flight D beats that arrive afterwards are flagged as unexpected.

Test Plan:
- Fairness: N_REQ=2, both requesters hold single-beat requests valid, a_ready=1 for 6 cycles -> a_source sequence is 0,1,0,1,0,1; cnt[0]=cnt[1]=3.
- Burst lock: requester 0 sends 4 beats (req_last on beat 4) while requester 1 is valid, a_ready toggles 1,0 -> a_source=0 for all 4 beats; requester 1 is granted only after beat 4 fires.
- Cap: requester 0 issues 4 single-beat requests with no D responses -> req_ready[0]=0 from then on; requester 1 is still granted. One D response with d_source=0 and d_last=1 -> requester 0 is granted again on the next request.
- Unexpected D: d_valid=1, d_source=1, cnt[1]=0 -> d_ready=1, rsp_valid=00, err_unexpected_d=1 for one cycle; no counter changes.
- Simultaneous update: cnt[0]=2, an A fire (last) and a D fire (last) for source 0 in the same cycle -> cnt[0] stays 2.
- Async reset mid-burst: drop reset_n during beat 2 of a 4-beat burst -> a_valid=0 and busy=0 immediately; after release, round-robin restarts at requester 0.
